// File: rtl/vga_pattern_timing_if.sv
// ----------------------------------------------------------------------------
// vga_pattern_timing_if
// Bundles the pixel-side signals of vga_pattern_timing.
//   master : the timing generator (drives raster, sync and colour outputs)
//   slave  : the consumer / pixel source (drives enable, mode and pixel data)
// Signals:
//   enable, mode, solid_rgb, ext_rgb   -> into the generator
//   x, y, pix_req                      <- current counter position (unregistered)
//   frame_start, HSync, VSync, de      <- registered timing, aligned with colour
//   red, green, blue                   <- registered pixel colour
// COLOR_W must match the COLOR_W of the vga_pattern_timing instance it connects.
// ----------------------------------------------------------------------------
interface vga_pattern_timing_if #(
    parameter int COLOR_W = 4
);
    logic                   enable;
    logic [1:0]             mode;
    logic [3*COLOR_W-1:0]   solid_rgb;
    logic [3*COLOR_W-1:0]   ext_rgb;
    logic [10:0]            x;
    logic [9:0]             y;
    logic                   pix_req;
    logic                   frame_start;
    logic                   HSync;
    logic                   VSync;
    logic                   de;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;

    modport master (
        input  enable, mode, solid_rgb, ext_rgb,
        output x, y, pix_req, frame_start, HSync, VSync, de, red, green, blue
    );

    modport slave (
        output enable, mode, solid_rgb, ext_rgb,
        input  x, y, pix_req, frame_start, HSync, VSync, de, red, green, blue
    );
endinterface

// File: rtl/vga_pattern_timing.sv
// ----------------------------------------------------------------------------
// vga_pattern_timing
// Parametrised VGA raster timing generator with four pixel sources
// (colour bars, checkerboard, solid colour, external pixel stream).
// Ports:
//   pixClock  - pixel clock
//   resetN    - asynchronous, active-low reset
//   vga       - vga_pattern_timing_if.master: enable/mode/solid_rgb/ext_rgb in;
//               x/y/pix_req (live counters), frame_start/HSync/VSync/de and
//               red/green/blue (registered one cycle after the counters) out
// ----------------------------------------------------------------------------
module vga_pattern_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int COLOR_W    = 4,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                   pixClock,
    input  logic                   resetN,
    vga_pattern_timing_if.master   vga
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BAR_W      = 11'(H_ACTIVE / 8);
    localparam logic [10:0] BARS_END   = 11'(8 * (H_ACTIVE / 8));
    localparam logic [COLOR_W-1:0] MAXV = '1;

    logic [10:0]         r_h;
    logic [9:0]          r_v;
    logic [1:0]          r_modeQ;
    logic                r_hSync;
    logic                r_vSync;
    logic                r_de;
    logic                r_frameStart;
    logic [COLOR_W-1:0]  r_red;
    logic [COLOR_W-1:0]  r_green;
    logic [COLOR_W-1:0]  r_blue;

    logic                w_hLast;
    logic                w_vLast;
    logic                w_active;
    logic                w_hSync;
    logic                w_vSync;
    logic [2:0]          w_barIdx;
    logic [COLOR_W-1:0]  w_red;
    logic [COLOR_W-1:0]  w_green;
    logic [COLOR_W-1:0]  w_blue;

    assign w_hLast  = (r_h == H_LAST);
    assign w_vLast  = (r_v == V_LAST);
    assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hSync  = ((r_h >= HS_START) && (r_h < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign w_vSync  = ((r_v >= VS_START) && (r_v < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign w_barIdx = 3'(r_h / BAR_W);

    // Raster counters: h runs across the line, v advances on the last pixel.
    always_ff @(posedge pixClock or negedge resetN) begin
        if (!resetN) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_hLast) begin
            r_h <= '0;
            r_v <= w_vLast ? '0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 11'd1;
        end
    end

    // The mode only changes on the very last pixel of a frame so a frame is
    // never drawn with two different sources.
    always_ff @(posedge pixClock or negedge resetN) begin
        if (!resetN) begin
            r_modeQ <= 2'd0;
        end else if (w_hLast && w_vLast) begin
            r_modeQ <= vga.mode;
        end
    end

    // Pixel source selection. Bar order white, yellow, cyan, green, magenta,
    // red, blue, black maps onto the bar index bits as r=~b1, g=~b2, b=~b0.
    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (vga.enable && w_active) begin
            case (r_modeQ)
                2'd0: begin
                    if (r_h < BARS_END) begin
                        w_red   = {COLOR_W{~w_barIdx[1]}};
                        w_green = {COLOR_W{~w_barIdx[2]}};
                        w_blue  = {COLOR_W{~w_barIdx[0]}};
                    end
                end
                2'd1: begin
                    if (!(r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2])) begin
                        w_red   = MAXV;
                        w_green = MAXV;
                        w_blue  = MAXV;
                    end
                end
                2'd2: {w_red, w_green, w_blue} = vga.solid_rgb;
                default: {w_red, w_green, w_blue} = vga.ext_rgb;
            endcase
        end
    end

    // Output stage: sync, data-enable, frame marker and colour all register
    // from the same counter state, so they stay mutually aligned.
    always_ff @(posedge pixClock or negedge resetN) begin
        if (!resetN) begin
            r_hSync      <= ~SYNC_POL;
            r_vSync      <= ~SYNC_POL;
            r_de         <= 1'b0;
            r_frameStart <= 1'b0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
        end else begin
            r_hSync      <= w_hSync;
            r_vSync      <= w_vSync;
            r_de         <= w_active;
            r_frameStart <= (r_h == 11'd0) && (r_v == 10'd0);
            r_red        <= w_red;
            r_green      <= w_green;
            r_blue       <= w_blue;
        end
    end

    assign vga.x           = r_h;
    assign vga.y           = r_v;
    assign vga.pix_req     = w_active;
    assign vga.HSync       = r_hSync;
    assign vga.VSync       = r_vSync;
    assign vga.de          = r_de;
    assign vga.frame_start = r_frameStart;
    assign vga.red         = r_red;
    assign vga.green       = r_green;
    assign vga.blue        = r_blue;

endmodule

// File: tb/tb_vga_pattern_timing.sv
// ----------------------------------------------------------------------------
// tb_vga_pattern_timing
// Directed bench for vga_pattern_timing. Three instances with independent
// resets: A (default line timing, short frame), B (small raster for the
// checkerboard), C (wide line, positive sync, 8-bit colour).
// ----------------------------------------------------------------------------
module tb_vga_pattern_timing;

    logic pixClock = 1'b0;
    always #5 pixClock = ~pixClock;

    logic rstA;
    logic rstB;
    logic rstC;

    vga_pattern_timing_if #(.COLOR_W(4)) ifA ();
    vga_pattern_timing_if #(.COLOR_W(4)) ifB ();
    vga_pattern_timing_if #(.COLOR_W(8)) ifC ();

    // External source presents {x[3:0], y[3:0], 5} for the current position.
    assign ifA.ext_rgb = {ifA.x[3:0], ifA.y[3:0], 4'h5};
    assign ifB.ext_rgb = '0;
    assign ifC.ext_rgb = '0;

    vga_pattern_timing #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dutA (
        .pixClock(pixClock), .resetN(rstA), .vga(ifA)
    );

    vga_pattern_timing #(
        .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(40), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dutB (
        .pixClock(pixClock), .resetN(rstB), .vga(ifB)
    );

    vga_pattern_timing #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .COLOR_W(8)
    ) dutC (
        .pixClock(pixClock), .resetN(rstC), .vga(ifC)
    );

    int total = 0;
    int bad   = 0;

    int sx, sy, spr, sr, sg, sb, sde, sfs, shs, svs;

    typedef struct {
        int r;
        int g;
        int b;
        int de;
    } expT;

    expT   sbQ[$];
    string tagQ[$];

    // Copy the selected instance's outputs into the sample variables.
    function automatic void snap(input int w);
        case (w)
            0: begin
                sx = int'(ifA.x); sy = int'(ifA.y); spr = int'(ifA.pix_req);
                sr = int'(ifA.red); sg = int'(ifA.green); sb = int'(ifA.blue);
                sde = int'(ifA.de); sfs = int'(ifA.frame_start);
                shs = int'(ifA.HSync); svs = int'(ifA.VSync);
            end
            1: begin
                sx = int'(ifB.x); sy = int'(ifB.y); spr = int'(ifB.pix_req);
                sr = int'(ifB.red); sg = int'(ifB.green); sb = int'(ifB.blue);
                sde = int'(ifB.de); sfs = int'(ifB.frame_start);
                shs = int'(ifB.HSync); svs = int'(ifB.VSync);
            end
            default: begin
                sx = int'(ifC.x); sy = int'(ifC.y); spr = int'(ifC.pix_req);
                sr = int'(ifC.red); sg = int'(ifC.green); sb = int'(ifC.blue);
                sde = int'(ifC.de); sfs = int'(ifC.frame_start);
                shs = int'(ifC.HSync); svs = int'(ifC.VSync);
            end
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance (sampling 1 ns after each edge) until the counters show (tx,ty).
    task automatic waitXY(input int w, input string tag, input int tx, input int ty);
        int n;
        n = 0;
        snap(w);
        while (!(sx == tx && sy == ty) && n < 20000) begin
            @(posedge pixClock); #1;
            n++;
            snap(w);
        end
        check({tag, "_reach"}, sx * 1024 + sy, tx * 1024 + ty);
    endtask

    // Wait for the counters to present (tx,ty) and queue the colour that
    // pixel must have when it reaches the registered outputs.
    task automatic applyStimulus(input int w, input string tag, input int tx, input int ty,
                                 input int er, input int eg, input int eb, input int ede);
        expT e;
        waitXY(w, tag, tx, ty);
        e.r = er; e.g = eg; e.b = eb; e.de = ede;
        sbQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    // One edge later the queued pixel is on the outputs.
    task automatic checkOutput(input int w);
        expT   e;
        string t;
        @(posedge pixClock); #1;
        e = sbQ.pop_front();
        t = tagQ.pop_front();
        snap(w);
        check({t, "_r"}, sr, e.r);
        check({t, "_g"}, sg, e.g);
        check({t, "_b"}, sb, e.b);
        check({t, "_de"}, sde, e.de);
    endtask

    task automatic checkPixel(input int w, input string tag, input int tx, input int ty,
                              input int er, input int eg, input int eb, input int ede);
        applyStimulus(w, tag, tx, ty, er, eg, eb, ede);
        checkOutput(w);
    endtask

    initial begin
        int fsCount, fs1, fs2, hsLow, hsFirst, hsLast0, vsLow, vsFirst, deTot, deLine0;
        int hsHigh, hsFirstHigh, deRise, prevDe;

        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        ifA.enable = 1'b1; ifA.mode = 2'd0; ifA.solid_rgb = '0;
        ifB.enable = 1'b1; ifB.mode = 2'd1; ifB.solid_rgb = '0;
        ifC.enable = 1'b1; ifC.mode = 2'd0; ifC.solid_rgb = '0;

        repeat (2) @(posedge pixClock);
        #1;

        // Reset values
        snap(0);
        check("rst_hs", shs, 1);
        check("rst_vs", svs, 1);
        check("rst_de", sde, 0);
        check("rst_fs", sfs, 0);
        check("rst_r", sr, 0);
        check("rst_x", sx, 0);
        check("rst_y", sy, 0);
        check("rst_pixreq", spr, 1);
        snap(2);
        check("c_rst_hs", shs, 0);
        check("c_rst_vs", svs, 0);

        // First edge after release shows pixel (0,0)
        @(negedge pixClock);
        rstA = 1'b1;
        @(posedge pixClock); #1;
        snap(0);
        check("rel0_fs", sfs, 1);
        check("rel0_de", sde, 1);
        check("rel0_r", sr, 15);
        check("rel0_g", sg, 15);
        check("rel0_b", sb, 15);
        check("rel0_x", sx, 1);

        // Two frames of timing measurement (frame = 800 x 8 = 6400 cycles)
        fsCount = 0; fs1 = -1; fs2 = -1; hsLow = 0; hsFirst = -1; hsLast0 = -1;
        vsLow = 0; vsFirst = -1; deTot = 0; deLine0 = 0;
        for (int k = 0; k <= 12800; k++) begin
            if (k > 0) begin
                @(posedge pixClock); #1;
            end
            snap(0);
            if (sfs == 1) begin
                fsCount++;
                if (fsCount == 2) fs1 = k;
                if (fsCount == 3) fs2 = k;
            end
            if (k < 12800) begin
                if (shs == 0) begin
                    hsLow++;
                    if (hsFirst < 0) hsFirst = k;
                    if (k < 800) hsLast0 = k;
                end
                if (svs == 0) begin
                    vsLow++;
                    if (vsFirst < 0) vsFirst = k;
                end
                if (sde == 1) begin
                    deTot++;
                    if (k < 800) deLine0++;
                end
            end
        end
        check("fs_count", fsCount, 3);
        check("fs_period1", fs1, 6400);
        check("fs_period2", fs2 - fs1, 6400);
        check("hs_low_total", hsLow, 16 * 96);
        check("hs_first_low", hsFirst, 656);
        check("hs_last_low", hsLast0, 751);
        check("vs_low_total", vsLow, 2 * 2 * 800);
        check("vs_first_low", vsFirst, 5 * 800);
        check("de_total", deTot, 2 * 4 * 640);
        check("de_line0", deLine0, 640);

        // Colour bars on line 1
        checkPixel(0, "bar0", 0, 1, 15, 15, 15, 1);
        checkPixel(0, "bar0_end", 79, 1, 15, 15, 15, 1);
        checkPixel(0, "bar1", 80, 1, 15, 15, 0, 1);
        checkPixel(0, "bar2", 160, 1, 0, 15, 15, 1);
        checkPixel(0, "bar5", 400, 1, 15, 0, 0, 1);
        checkPixel(0, "bar7", 639, 1, 0, 0, 0, 1);
        checkPixel(0, "blank", 640, 1, 0, 0, 0, 0);

        // Enable forces black but keeps de
        ifA.enable = 1'b0;
        checkPixel(0, "en_off", 0, 2, 0, 0, 0, 1);
        ifA.enable = 1'b1;
        checkPixel(0, "en_on", 10, 2, 15, 15, 15, 1);

        // Mid-frame switch to solid colour waits for the next frame
        ifA.mode = 2'd2;
        ifA.solid_rgb = 12'hA5C;
        checkPixel(0, "sw_keep", 80, 3, 15, 15, 0, 1);
        checkPixel(0, "sw_new", 0, 0, 10, 5, 12, 1);

        // External pixel mode
        ifA.mode = 2'd3;
        checkPixel(0, "m3_keep", 7, 3, 10, 5, 12, 1);
        checkPixel(0, "ext_a", 2, 1, 2, 1, 5, 1);
        checkPixel(0, "ext_b", 7, 3, 7, 3, 5, 1);

        // Mid-frame reset
        waitXY(0, "rst_pt", 300, 2);
        check("pre_rst_r", sr, 11);
        rstA = 1'b0;
        #1;
        snap(0);
        check("mid_rst_hs", shs, 1);
        check("mid_rst_vs", svs, 1);
        check("mid_rst_de", sde, 0);
        check("mid_rst_r", sr, 0);
        check("mid_rst_g", sg, 0);
        check("mid_rst_x", sx, 0);
        check("mid_rst_y", sy, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge pixClock); #1;
            snap(0);
            check("hold_x", sx, 0);
            check("hold_de", sde, 0);
            check("hold_b", sb, 0);
            check("hold_fs", sfs, 0);
        end
        @(negedge pixClock);
        rstA = 1'b1;
        @(posedge pixClock); #1;
        snap(0);
        check("rel_fs", sfs, 1);
        check("rel_de", sde, 1);
        check("rel_r", sr, 15);
        check("rel_g", sg, 15);
        check("rel_b", sb, 15);
        check("rel_x", sx, 1);
        @(posedge pixClock); #1;
        snap(0);
        check("rel_fs_end", sfs, 0);

        // Checkerboard (mode 1 takes effect from the second frame)
        @(negedge pixClock);
        rstB = 1'b1;
        @(posedge pixClock); #1;
        checkPixel(1, "chk_0_0", 0, 0, 15, 15, 15, 1);
        checkPixel(1, "chk_31_0", 31, 0, 15, 15, 15, 1);
        checkPixel(1, "chk_32_0", 32, 0, 0, 0, 0, 1);
        checkPixel(1, "chk_0_32", 0, 32, 0, 0, 0, 1);
        checkPixel(1, "chk_32_32", 32, 32, 15, 15, 15, 1);

        // Wide line, positive sync, 8-bit colour
        @(negedge pixClock);
        rstC = 1'b1;
        hsHigh = 0; hsFirstHigh = -1; deRise = -1; prevDe = 1;
        for (int k = 0; k <= 1100; k++) begin
            @(posedge pixClock); #1;
            snap(2);
            if (k == 0) begin
                check("c_fs", sfs, 1);
                check("c_bar0_r", sr, 255);
                check("c_bar0_g", sg, 255);
                check("c_bar0_b", sb, 255);
                check("c_vs_idle", svs, 0);
            end
            if (k == 100) begin
                check("c_bar1_r", sr, 255);
                check("c_bar1_b", sb, 0);
            end
            if (k < 1056 && shs == 1) begin
                hsHigh++;
                if (hsFirstHigh < 0) hsFirstHigh = k;
            end
            if (k > 0 && sde == 1 && prevDe == 0 && deRise < 0) deRise = k;
            prevDe = sde;
        end
        check("c_hs_high", hsHigh, 128);
        check("c_hs_first", hsFirstHigh, 840);
        check("c_line_period", deRise, 1056);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_pattern_timing.md
# vga_pattern_timing

Parametrised VGA raster timing generator and test-pattern source. It replaces the fixed 640x480 colour-bar generator with configurable porch, sync and active widths, configurable sync polarity and colour depth, and four selectable pixel sources. Two downstream uses share the same raster: the camera frame-buffer read path uses the external-pixel mode, and board bring-up uses the internal patterns.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- COLOR_W, 4, bits per colour channel
- SYNC_POL, 0, asserted level of HSync/VSync (0 = active-low)
- CHECK_LOG2, 5, checkerboard square size is 2^CHECK_LOG2 pixels
- pixClock  in  1  pixel clock
- resetN  in  1  reset, asynchronous, active-low
- enable  in  1  1 = drive colour; 0 = force black, timing continues
- mode  in  2  pixel source: 0 colour bars, 1 checkerboard, 2 solid, 3 external
- solid_rgb  in  3*COLOR_W  {r,g,b} used in mode 2
- ext_rgb  in  3*COLOR_W  {r,g,b} for the current x/y, used in mode 3
- x  out  11  current horizontal count (pixel request address)
- y  out  10  current vertical count (line request address)
- pix_req  out  1  1 when (x,y) is inside the active area
- frame_start  out  1  one-cycle pulse, registered, at output pixel (0,0)
- HSync  out  1  horizontal sync
- VSync  out  1  vertical sync
- de  out  1  registered data-enable aligned with red/green/blue
- red, green, blue  out  COLOR_W each  pixel colour

## Operation
- Counters: h 0..H_TOT-1, with H_TOT = sum of H_*. v 0..V_TOT-1 (V_TOT likewise). h wraps at H_TOT-1 and increments v. v wraps at V_TOT-1. Defaults give 800 x 525.
- Line layout: active at h < H_ACTIVE, then front porch, then sync at H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, then back porch. The frame uses the same layout with v and the V_* parameters.
- x = h and y = v, driven directly from the counters. pix_req = (h < H_ACTIVE) && (v < V_ACTIVE).
- Mode is captured into mode_q only on the last pixel of the frame (h = H_TOT-1, v = V_TOT-1). A mid-frame change never tears the frame. Reset sets mode_q = 0.
- Pattern for active pixels, where MAX = 2^COLOR_W-1:
  - Mode 0: 8 vertical bars, each H_ACTIVE/8 wide (integer division); pixels past 8*bar width are black. Bar order: white, yellow, cyan, green, magenta, red, blue, black. Channels are 0 or MAX.
  - Mode 1: all channels MAX when x[CHECK_LOG2] ^ y[CHECK_LOG2] = 0, else all 0.
  - Mode 2: solid_rgb.
  - Mode 3: ext_rgb sampled in the same cycle as the matching x/y.
- Outside the active area, or when enable = 0, the colour is 0. de is still driven from pix_req.
- Sync outputs equal SYNC_POL inside the sync window and ~SYNC_POL elsewhere.

## Timing
- Reset values: h = v = 0; HSync = VSync = ~SYNC_POL; red/green/blue = 0; de = 0; frame_start = 0; mode_q = 0. x, y and pix_req follow the counters (0, 0, 1).
- Latency: HSync, VSync, de, colour and frame_start are registered exactly 1 cycle after the counter state that produces them. All five stay mutually aligned.
- ext_rgb contract: the source presents pixel (x,y) combinationally or from a 0-latency register in the cycle x/y show it. It appears on red/green/blue the next cycle.
- frame_start is high for one cycle, the cycle the (0,0) pixel is on the outputs. Its period is H_TOT*V_TOT cycles, which is 420000 at defaults.
- First rising edge after resetN deasserts: outputs show pixel (0,0) and frame_start = 1.
- A reset asserted mid-frame immediately forces all registered outputs to their reset values. There is no partial-frame recovery.
- An enable change takes effect on the next registered pixel and does not disturb timing.

## Test plan
- Defaults, release reset, run 2 frames.
  - Required: HSync low for 96 cycles per 800-cycle line, low from registered pixel 656 through 751.
  - Required: VSync low for 2 lines starting at line 490.
  - Required: frame_start period 420000, de high for 640 cycles on each of 480 lines.
- Mode 0.
  - Required: output pixel 0 = (15,15,15); 80 = (15,15,0); 400 = (15,0,0); 639 = (0,0,0); 640 = (0,0,0).
- Mode 1.
  - Required: (x=0,y=0) white; (x=32,y=0) black; (x=32,y=32) white.
- Mode 3 with ext_rgb = {x[3:0], y[3:0], 4'h5}.
  - Required: at x=7, y=3 the output one cycle later is (7,3,5).
- Switch mode 0->2 at line 100 with solid_rgb = 12'hA5C.
  - Required: the rest of the frame stays colour bars.
  - Required: the next frame's pixel (0,0) = (10,5,12).
- Non-default parameters H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, SYNC_POL=1, COLOR_W=8.
  - Required: line period 1056, HSync high for 128 cycles, bar 0 = (255,255,255).
- Assert resetN low at line 200 for 3 cycles.
  - Required: outputs are at reset values while low.
  - Required: frame_start fires on the first edge after release.
